// File: rtl/dmem_ctrl_pkg.sv
// Shared definitions for the data-memory port controller: FSM states,
// requester port identifiers and the address-legality check.
package dmem_ctrl_pkg;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_BUSY = 2'd1,
        ST_DONE = 2'd2
    } state_e;

    localparam logic PORT_CPU = 1'b0;
    localparam logic PORT_DMA = 1'b1;

    // A legal access is word aligned and falls inside the memory array.
    function automatic logic addr_legal(input logic [63:0] addr,
                                        input int unsigned depth);
        return (addr[1:0] == 2'b00) && (addr < (64'(depth) << 2));
    endfunction

endpackage

// File: rtl/dmem_port_ctrl_rr_arb2.sv
// Two-way round-robin arbiter: on a tie, grant the port not served last.
module rr_arb2
    import dmem_ctrl_pkg::*;
(
    input  logic       clk_i,
    input  logic       rst_i,
    input  logic [1:0] req,
    input  logic       update,
    output logic [1:0] gnt
);

    logic last_q;

    // Grant selection: a lone requester always wins, a tie goes to the other port.
    always_comb begin
        gnt = 2'b00;
        if (req[0] && (!req[1] || (last_q == PORT_DMA))) begin
            gnt[0] = 1'b1;
        end else if (req[1]) begin
            gnt[1] = 1'b1;
        end
    end

    // Remember which port was granted most recently.
    always_ff @(posedge clk_i or negedge rst_i) begin
        if (!rst_i) begin
            last_q <= PORT_DMA;
        end else if (update && (gnt != 2'b00)) begin
            last_q <= gnt[1];
        end
    end

endmodule

// File: rtl/dmem_port_ctrl.sv
// Sequences fixed-latency accesses to a single-port data memory shared by
// the CPU MEM stage (port 0) and a DMA/debug loader (port 1).
module dmem_port_ctrl
    import dmem_ctrl_pkg::*;
#(
    parameter int          DATA_W    = 32,
    parameter int          ADDR_W    = 32,
    parameter int unsigned MEM_DEPTH = 32,
    parameter int          MEM_LAT   = 2
) (
    input  logic              clk_i,
    input  logic              rst_i,
    input  logic              cpu_req_i,
    input  logic              cpu_we_i,
    input  logic [ADDR_W-1:0] cpu_addr_i,
    input  logic [DATA_W-1:0] cpu_wdata_i,
    output logic [DATA_W-1:0] cpu_rdata_o,
    output logic              cpu_ack_o,
    output logic              cpu_stall_o,
    input  logic              dma_req_i,
    input  logic              dma_we_i,
    input  logic [ADDR_W-1:0] dma_addr_i,
    input  logic [DATA_W-1:0] dma_wdata_i,
    output logic [DATA_W-1:0] dma_rdata_o,
    output logic              dma_ack_o,
    output logic              err_o,
    output logic              mem_en_o,
    output logic              mem_we_o,
    output logic [ADDR_W-1:0] mem_addr_o,
    output logic [DATA_W-1:0] mem_wdata_o,
    input  logic [DATA_W-1:0] mem_rdata_i
);

    localparam int CNT_W = (MEM_LAT > 1) ? $clog2(MEM_LAT) : 1;

    state_e            state;
    logic [CNT_W-1:0]  count;
    logic              port_q;
    logic              we_q;
    logic              legal_q;

    logic [1:0]        req;
    logic [1:0]        gnt;
    logic              arb_upd;
    logic              sel_we;
    logic [ADDR_W-1:0] sel_addr;
    logic [DATA_W-1:0] sel_wdata;
    logic              sel_legal;
    logic [DATA_W-1:0] rd_cap;

    assign req     = {dma_req_i, cpu_req_i};
    assign arb_upd = (state == ST_IDLE);

    rr_arb2 u_arb (
        .clk_i  (clk_i),
        .rst_i  (rst_i),
        .req    (req),
        .update (arb_upd),
        .gnt    (gnt)
    );

    // Mux the granted requester's fields and judge its address.
    always_comb begin
        sel_we    = gnt[1] ? dma_we_i    : cpu_we_i;
        sel_addr  = gnt[1] ? dma_addr_i  : cpu_addr_i;
        sel_wdata = gnt[1] ? dma_wdata_i : cpu_wdata_i;
        sel_legal = addr_legal(64'(sel_addr), MEM_DEPTH);
        rd_cap    = (legal_q && !we_q) ? mem_rdata_i : '0;
    end

    // The pipeline waits until its own access has been acknowledged.
    assign cpu_stall_o = cpu_req_i & ~cpu_ack_o;

    // Access sequencer: accept a grant, hold the memory busy, then acknowledge.
    always_ff @(posedge clk_i or negedge rst_i) begin
        if (!rst_i) begin
            state       <= ST_IDLE;
            count       <= '0;
            port_q      <= PORT_CPU;
            we_q        <= 1'b0;
            legal_q     <= 1'b0;
            cpu_rdata_o <= '0;
            cpu_ack_o   <= 1'b0;
            dma_rdata_o <= '0;
            dma_ack_o   <= 1'b0;
            err_o       <= 1'b0;
            mem_en_o    <= 1'b0;
            mem_we_o    <= 1'b0;
            mem_addr_o  <= '0;
            mem_wdata_o <= '0;
        end else begin
            cpu_ack_o   <= 1'b0;
            dma_ack_o   <= 1'b0;
            err_o       <= 1'b0;
            cpu_rdata_o <= '0;
            dma_rdata_o <= '0;
            case (state)
                ST_IDLE: begin
                    if (req != 2'b00) begin
                        port_q      <= gnt[1];
                        we_q        <= sel_we;
                        legal_q     <= sel_legal;
                        mem_addr_o  <= {sel_addr[ADDR_W-1:2], 2'b00};
                        mem_wdata_o <= sel_wdata;
                        mem_en_o    <= sel_legal;
                        mem_we_o    <= sel_legal & sel_we;
                        count       <= CNT_W'(MEM_LAT - 1);
                        state       <= ST_BUSY;
                    end
                end
                ST_BUSY: begin
                    mem_we_o <= 1'b0;
                    if (count == '0) begin
                        mem_en_o <= 1'b0;
                        err_o    <= ~legal_q;
                        if (port_q == PORT_DMA) begin
                            dma_ack_o   <= 1'b1;
                            dma_rdata_o <= rd_cap;
                        end else begin
                            cpu_ack_o   <= 1'b1;
                            cpu_rdata_o <= rd_cap;
                        end
                        state <= ST_DONE;
                    end else begin
                        count <= count - 1'b1;
                    end
                end
                ST_DONE: begin
                    state <= ST_IDLE;
                end
                default: begin
                    state <= ST_IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_dmem_port_ctrl.sv
// Bench for dmem_port_ctrl: table-driven single accesses, hand-written
// multi-port/reset sequences and a randomized two-port run against a
// transaction-level reference model.
module tb_dmem_port_ctrl;

    localparam int DATA_W    = 32;
    localparam int ADDR_W    = 32;
    localparam int MEM_DEPTH = 32;
    localparam int MEM_LAT   = 2;
    localparam int ACK_LAT   = MEM_LAT + 1;
    localparam int RND_CYC   = 700;

    logic              clk_i = 1'b0;
    logic              rst_i = 1'b0;
    logic              cpu_req_i = 1'b0, cpu_we_i = 1'b0;
    logic [ADDR_W-1:0] cpu_addr_i = '0;
    logic [DATA_W-1:0] cpu_wdata_i = '0;
    logic [DATA_W-1:0] cpu_rdata_o;
    logic              cpu_ack_o, cpu_stall_o;
    logic              dma_req_i = 1'b0, dma_we_i = 1'b0;
    logic [ADDR_W-1:0] dma_addr_i = '0;
    logic [DATA_W-1:0] dma_wdata_i = '0;
    logic [DATA_W-1:0] dma_rdata_o;
    logic              dma_ack_o, err_o, mem_en_o, mem_we_o;
    logic [ADDR_W-1:0] mem_addr_o;
    logic [DATA_W-1:0] mem_wdata_o;
    logic [DATA_W-1:0] mem_rdata_i;

    always #5 clk_i = ~clk_i;

    dmem_port_ctrl #(.DATA_W(DATA_W), .ADDR_W(ADDR_W), .MEM_DEPTH(MEM_DEPTH), .MEM_LAT(MEM_LAT)) dut (
        .clk_i(clk_i), .rst_i(rst_i),
        .cpu_req_i(cpu_req_i), .cpu_we_i(cpu_we_i), .cpu_addr_i(cpu_addr_i),
        .cpu_wdata_i(cpu_wdata_i), .cpu_rdata_o(cpu_rdata_o), .cpu_ack_o(cpu_ack_o),
        .cpu_stall_o(cpu_stall_o),
        .dma_req_i(dma_req_i), .dma_we_i(dma_we_i), .dma_addr_i(dma_addr_i),
        .dma_wdata_i(dma_wdata_i), .dma_rdata_o(dma_rdata_o), .dma_ack_o(dma_ack_o),
        .err_o(err_o), .mem_en_o(mem_en_o), .mem_we_o(mem_we_o),
        .mem_addr_o(mem_addr_o), .mem_wdata_o(mem_wdata_o), .mem_rdata_i(mem_rdata_i)
    );

    // Behavioural single-port memory
    logic [31:0] dmem [32];
    logic [31:0] init_mem [32];
    logic        load_mem = 1'b0;

    always @(posedge clk_i) begin
        if (load_mem) begin
            for (int i = 0; i < 32; i++) dmem[i] <= init_mem[i];
        end else if (mem_we_o) begin
            dmem[mem_addr_o[6:2]] <= mem_wdata_o;
        end
    end
    assign mem_rdata_i = dmem[mem_addr_o[6:2]];

    int en_cnt = 0, we_cnt = 0;
    always @(negedge clk_i) begin
        if (mem_en_o) en_cnt++;
        if (mem_we_o) we_cnt++;
    end

    int checks = 0, failures = 0;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%0h required=%0h", name, act, exp);
        end
    endtask

    task automatic chk_zero(input string name);
        chk({name, "_ctl"}, {58'd0, cpu_ack_o, dma_ack_o, err_o, mem_en_o, mem_we_o, cpu_stall_o}, 64'd0);
        chk({name, "_dat"}, {32'd0, cpu_rdata_o | dma_rdata_o | mem_addr_o | mem_wdata_o}, 64'd0);
    endtask

    task automatic preload();
        for (int i = 0; i < 32; i++) init_mem[i] = 32'h100 + i;
        init_mem[0] = 32'd5;
        init_mem[2] = 32'd10;
        init_mem[5] = 32'd0;
        @(posedge clk_i); #1 load_mem = 1'b1;
        @(posedge clk_i); #1 load_mem = 1'b0;
    endtask

    task automatic clear_inputs();
        cpu_req_i = 0; cpu_we_i = 0; cpu_addr_i = '0; cpu_wdata_i = '0;
        dma_req_i = 0; dma_we_i = 0; dma_addr_i = '0; dma_wdata_i = '0;
    endtask

    // Assert reset for two cycles; leaves rst_i low for the caller to release.
    task automatic hold_reset(input string name);
        rst_i = 1'b0;
        clear_inputs();
        repeat (2) @(negedge clk_i);
        chk_zero(name);
        @(posedge clk_i); #1;
    endtask

    task automatic drive(input logic p, input logic we, input logic [31:0] addr, input logic [31:0] wd);
        if (p) begin
            dma_req_i = 1; dma_we_i = we; dma_addr_i = addr; dma_wdata_i = wd;
        end else begin
            cpu_req_i = 1; cpu_we_i = we; cpu_addr_i = addr; cpu_wdata_i = wd;
        end
    endtask

    // One access on one port; measures latency, result, strobes and stall.
    task automatic single(input logic p, input logic we, input logic [31:0] addr, input logic [31:0] wd,
                          output int lat, output logic [31:0] rd, output logic er,
                          output int en_d, output int we_d, output int other, output int stall_bad);
        int e0, w0;
        e0 = en_cnt; w0 = we_cnt;
        lat = -1; rd = '0; er = 1'b0; other = 0; stall_bad = 0;
        @(posedge clk_i); #1 drive(p, we, addr, wd);
        for (int k = 0; k < 20 && lat < 0; k++) begin
            @(negedge clk_i);
            if (p ? dma_ack_o : cpu_ack_o) begin
                lat = k; rd = p ? dma_rdata_o : cpu_rdata_o; er = err_o;
            end
            if (p ? cpu_ack_o : dma_ack_o) other++;
            if (!p && (cpu_stall_o !== (k != ACK_LAT))) stall_bad++;
        end
        @(posedge clk_i); #1 clear_inputs();
        @(posedge clk_i); #1;
        en_d = en_cnt - e0;
        we_d = we_cnt - w0;
    endtask

    int cack_q[$], dack_q[$];
    logic [31:0] crd_q[$], drd_q[$];

    // Observe n cycles from the cycle requests were raised; optionally drop a req on its ack.
    task automatic watch(input int n, input bit drop_on_ack);
        bit dc, dd;
        cack_q.delete(); dack_q.delete(); crd_q.delete(); drd_q.delete();
        for (int k = 0; k < n; k++) begin
            @(negedge clk_i);
            dc = 0; dd = 0;
            if (cpu_ack_o) begin cack_q.push_back(k); crd_q.push_back(cpu_rdata_o); dc = 1; end
            if (dma_ack_o) begin dack_q.push_back(k); drd_q.push_back(dma_rdata_o); dd = 1; end
            @(posedge clk_i); #1;
            if (drop_on_ack && dc) cpu_req_i = 0;
            if (drop_on_ack && dd) dma_req_i = 0;
        end
    endtask

    function automatic int qi(input int q[$], input int i);
        return (q.size() > i) ? q[i] : -1;
    endfunction

    function automatic logic [31:0] rnd_addr();
        int r;
        r = $urandom_range(0, 9);
        if (r < 7) return 32'($urandom_range(0, 31)) << 2;
        if (r == 7) return (32'($urandom_range(0, 31)) << 2) | 32'($urandom_range(1, 3));
        if (r == 8) return 32'h80 + (32'($urandom_range(0, 63)) << 2);
        return 32'hFFFF_FFF0;
    endfunction

    typedef struct {
        logic        port;
        logic        we;
        logic [31:0] addr;
        logic [31:0] wdata;
        logic [31:0] exp_rd;
        logic        exp_err;
    } vec_t;

    vec_t vecs[11];

    initial begin
        int lat, en_d, we_d, other, sbad, w0, e0;
        logic [31:0] rd;
        logic er;
        logic [31:0] refmem [32];
        bit   pend, mlast, act_c, act_d;
        int   next_free, ack_cyc, exp_en, exp_we;
        logic pport, perr;
        logic [31:0] prd;

        vecs[0]  = '{1'b0, 1'b0, 32'h08, 32'h0,      32'd10,     1'b0};
        vecs[1]  = '{1'b0, 1'b0, 32'h06, 32'h0,      32'd0,      1'b1};
        vecs[2]  = '{1'b0, 1'b0, 32'h80, 32'h0,      32'd0,      1'b1};
        vecs[3]  = '{1'b1, 1'b1, 32'h14, 32'h1357,   32'd0,      1'b0};
        vecs[4]  = '{1'b1, 1'b0, 32'h14, 32'h0,      32'h1357,   1'b0};
        vecs[5]  = '{1'b0, 1'b1, 32'h7C, 32'h55AA,   32'd0,      1'b0};
        vecs[6]  = '{1'b0, 1'b0, 32'h7C, 32'h0,      32'h55AA,   1'b0};
        vecs[7]  = '{1'b1, 1'b0, 32'h00, 32'h0,      32'd5,      1'b0};
        vecs[8]  = '{1'b1, 1'b1, 32'h81, 32'hDEAD,   32'd0,      1'b1};
        vecs[9]  = '{1'b1, 1'b1, 32'h80, 32'hBEEF,   32'd0,      1'b1};
        vecs[10] = '{1'b0, 1'b0, 32'h00, 32'h0,      32'd5,      1'b0};

        // Reset state and table-driven single accesses
        preload();
        hold_reset("reset");
        rst_i = 1'b1;
        for (int i = 0; i < 11; i++) begin
            single(vecs[i].port, vecs[i].we, vecs[i].addr, vecs[i].wdata, lat, rd, er, en_d, we_d, other, sbad);
            chk($sformatf("v%0d_lat", i), lat, ACK_LAT);
            chk($sformatf("v%0d_rdata", i), rd, vecs[i].exp_rd);
            chk($sformatf("v%0d_err", i), er, vecs[i].exp_err);
            chk($sformatf("v%0d_en_cycles", i), en_d, vecs[i].exp_err ? 0 : MEM_LAT);
            chk($sformatf("v%0d_we_cycles", i), we_d, (!vecs[i].exp_err && vecs[i].we) ? 1 : 0);
            chk($sformatf("v%0d_other_ack", i), other, 0);
            chk($sformatf("v%0d_stall", i), sbad, 0);
        end
        chk("tbl_mem7c", dmem[31], 32'h55AA);
        chk("tbl_mem0_untouched", dmem[0], 32'd5);

        // Simultaneous requests at reset exit: CPU first
        preload();
        hold_reset("t2_reset");
        w0 = we_cnt;
        rst_i = 1'b1;
        drive(1'b0, 1'b0, 32'h00, 32'h0);
        drive(1'b1, 1'b1, 32'h14, 32'hABCD);
        watch(10, 1'b1);
        chk("t2_cpu_ack_cycle", qi(cack_q, 0), 3);
        chk("t2_cpu_rdata", (crd_q.size() > 0) ? crd_q[0] : 32'hFFFF_FFFF, 32'd5);
        chk("t2_dma_ack_cycle", qi(dack_q, 0), 7);
        chk("t2_ack_counts", {cack_q.size(), dack_q.size()}, {32'd1, 32'd1});
        chk("t2_mem5", dmem[5], 32'hABCD);
        chk("t2_we_cycles", we_cnt - w0, 1);
        clear_inputs();

        // Both held: alternate CPU, DMA, CPU every MEM_LAT+2 cycles
        hold_reset("t3_reset");
        rst_i = 1'b1;
        drive(1'b0, 1'b0, 32'h08, 32'h0);
        drive(1'b1, 1'b0, 32'h00, 32'h0);
        watch(12, 1'b0);
        chk("t3_cpu_ack0", qi(cack_q, 0), 3);
        chk("t3_dma_ack0", qi(dack_q, 0), 7);
        chk("t3_cpu_ack1", qi(cack_q, 1), 11);
        chk("t3_ack_counts", {cack_q.size(), dack_q.size()}, {32'd2, 32'd1});
        clear_inputs();
        repeat (4) @(posedge clk_i);
        #1;

        // Reset during the second BUSY cycle of a DMA read
        drive(1'b1, 1'b0, 32'h08, 32'h0);
        @(negedge clk_i);
        @(negedge clk_i);
        chk("t5_busy_en", mem_en_o, 1'b1);
        @(posedge clk_i); #1;
        rst_i = 1'b0;
        #1 chk_zero("t5_async_clear");
        clear_inputs();
        repeat (2) begin
            @(negedge clk_i);
            chk("t5_no_ack_in_reset", {cpu_ack_o, dma_ack_o}, 2'b00);
        end
        @(posedge clk_i); #1;
        rst_i = 1'b1;
        drive(1'b0, 1'b0, 32'h08, 32'h0);
        drive(1'b1, 1'b0, 32'h00, 32'h0);
        watch(9, 1'b1);
        chk("t5_cpu_first", qi(cack_q, 0), 3);
        chk("t5_dma_second", qi(dack_q, 0), 7);
        chk("t5_dma_rdata", (drd_q.size() > 0) ? drd_q[0] : 32'hFFFF_FFFF, 32'd5);
        clear_inputs();

        // DMA request dropped while busy: ack still pulses once
        @(posedge clk_i); #1;
        drive(1'b1, 1'b0, 32'h00, 32'h0);
        @(posedge clk_i); #1 dma_req_i = 1'b0;
        cack_q.delete(); dack_q.delete();
        for (int k = 1; k < 8; k++) begin
            @(negedge clk_i);
            if (dma_ack_o) dack_q.push_back(k);
            @(posedge clk_i); #1;
        end
        chk("t6_dma_ack_cycle", qi(dack_q, 0), 3);
        chk("t6_dma_ack_count", dack_q.size(), 1);
        drive(1'b0, 1'b0, 32'h08, 32'h0);
        watch(6, 1'b1);
        chk("t6_idle_after", qi(cack_q, 0), 3);
        chk("t6_rdata_after", (crd_q.size() > 0) ? crd_q[0] : 32'hFFFF_FFFF, 32'd10);
        clear_inputs();

        // Randomized two-port traffic against a transaction-level model
        preload();
        hold_reset("rnd_reset");
        rst_i = 1'b1;
        for (int i = 0; i < 32; i++) refmem[i] = init_mem[i];
        pend = 0; mlast = 1'b1; next_free = 0; ack_cyc = 0; exp_en = 0; exp_we = 0;
        pport = 0; perr = 0; prd = '0; act_c = 0; act_d = 0;
        e0 = en_cnt; w0 = we_cnt;
        for (int k = 0; k < RND_CYC; k++) begin
            bit ec, ed, dc, dd;
            logic p, we, legal;
            logic [31:0] a, wd;
            @(negedge clk_i);
            ec = pend && (k == ack_cyc) && (pport == 1'b0);
            ed = pend && (k == ack_cyc) && (pport == 1'b1);
            chk("rnd_cpu_ack", cpu_ack_o, ec);
            chk("rnd_dma_ack", dma_ack_o, ed);
            chk("rnd_stall", cpu_stall_o, cpu_req_i & ~ec);
            if (ec) chk("rnd_cpu_rdata", cpu_rdata_o, prd);
            if (ed) chk("rnd_dma_rdata", dma_rdata_o, prd);
            if (ec || ed) begin
                chk("rnd_err", err_o, perr);
                pend = 0;
            end
            dc = cpu_ack_o; dd = dma_ack_o;
            if (!pend && k >= next_free && (cpu_req_i || dma_req_i)) begin
                p     = (cpu_req_i && dma_req_i) ? ~mlast : dma_req_i;
                we    = p ? dma_we_i : cpu_we_i;
                a     = p ? dma_addr_i : cpu_addr_i;
                wd    = p ? dma_wdata_i : cpu_wdata_i;
                legal = (a % 4 == 0) && (a < 4 * MEM_DEPTH);
                prd   = (legal && !we) ? refmem[a / 4] : 32'd0;
                if (legal && we) begin
                    refmem[a / 4] = wd;
                    exp_we++;
                end
                if (legal) exp_en += MEM_LAT;
                perr = !legal; pport = p; mlast = p; pend = 1;
                ack_cyc = k + ACK_LAT;
                next_free = k + MEM_LAT + 2;
            end
            @(posedge clk_i); #1;
            if (act_c && dc) begin act_c = 0; cpu_req_i = 0; end
            if (act_d && dd) begin act_d = 0; dma_req_i = 0; end
            if (k < RND_CYC - 12) begin
                if (!act_c && $urandom_range(0, 2) == 0) begin
                    act_c = 1; drive(1'b0, 1'($urandom_range(0, 1)), rnd_addr(), $urandom);
                end
                if (!act_d && $urandom_range(0, 2) == 0) begin
                    act_d = 1; drive(1'b1, 1'($urandom_range(0, 1)), rnd_addr(), $urandom);
                end
            end
        end
        chk("rnd_drained", {act_c, act_d, pend}, 3'b000);
        chk("rnd_en_cycles", en_cnt - e0, exp_en);
        chk("rnd_we_cycles", we_cnt - w0, exp_we);
        for (int i = 0; i < 32; i++) chk($sformatf("rnd_mem%0d", i), dmem[i], refmem[i]);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
